// File: rtl/xdma_axis_frame_checker.sv
// ---------------------------------------------------------------------------
// xdma_axis_frame_checker
//
// AXI-Stream sink that sits on the xdma_rx_axis side of the UDP/CMAC wrapper.
// Each received frame is checked against a deterministic byte pattern, the
// configured frame length, tkeep legality and the upstream tuser error flag.
// Frame, error and byte counters plus a sticky error code are kept for
// loopback benches and bring-up status registers.
//
// Ports:
//   xdma_clk, xdma_reset          sole clock, synchronous active-high reset
//   xdma_rx_axis_*                AXI-Stream slave (tvalid/tready/tdata/
//                                 tkeep/tlast/tuser, tuser[0] = upstream err)
//   cfg_enable                    accept beats while high
//   cfg_stop_on_err               enter HALT after the first bad frame
//   cfg_frame_bytes               expected frame length, sampled on beat 0
//   frame_done / frame_err        one-cycle completion pulse and its verdict
//   frame_cnt                     completed frames (wraps)
//   err_cnt                       bad frames (saturates)
//   byte_cnt                      accepted bytes (wraps)
//   err_code                      sticky error classes:
//                                 [0] data, [1] tkeep, [2] length, [3] tuser
//   halted                        checker stopped until reset
// ---------------------------------------------------------------------------
module xdma_axis_frame_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  xdma_clk,
  input  logic                  xdma_reset,
  input  logic                  xdma_rx_axis_tvalid,
  output logic                  xdma_rx_axis_tready,
  input  logic [DATA_WIDTH-1:0] xdma_rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] xdma_rx_axis_tkeep,
  input  logic                  xdma_rx_axis_tlast,
  input  logic [USER_WIDTH-1:0] xdma_rx_axis_tuser,
  input  logic                  cfg_enable,
  input  logic                  cfg_stop_on_err,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_bytes,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [47:0]           byte_cnt,
  output logic [3:0]            err_code,
  output logic                  halted
);

  localparam int PW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_HALT} state_t;

  state_t state, state_next;

  logic                 beat;
  logic                 first_beat;
  logic [LEN_WIDTH-1:0] frame_len;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [PW-1:0]        len_acc;
  logic [PW-1:0]        len_base;
  logic [PW-1:0]        beat_bytes;
  logic [PW:0]          len_sum;
  logic [PW-1:0]        len_next;
  logic [7:0]           beat_base;
  logic [7:0]           byte_base;
  logic [15:0]          exp_seq;
  logic [3:0]           frame_flags;
  logic [3:0]           beat_flags;
  logic [3:0]           flags_next;
  logic [KEEP_WIDTH-1:0] keep_plus1;
  logic                 data_bad;
  logic                 keep_bad;
  logic                 len_bad;
  logic                 frame_bad;
  logic                 seq_hi_unused;

  // Only the low byte of the sequence number feeds the pattern.
  assign seq_hi_unused = ^exp_seq[15:8];

  assign beat   = xdma_rx_axis_tvalid & xdma_rx_axis_tready;
  assign halted = (state == ST_HALT);

  always_ff @(posedge xdma_clk) begin
    if (xdma_reset) state <= ST_IDLE;
    else            state <= state_next;
  end

  // HALT is chosen on the tlast beat itself so it becomes visible in the
  // same cycle as the completion pulse and the following beat is refused.
  always_comb begin
    state_next          = state;
    xdma_rx_axis_tready = cfg_enable & (state != ST_HALT);
    case (state)
      ST_IDLE, ST_RECV: begin
        if (beat) begin
          if (xdma_rx_axis_tlast)
            state_next = (frame_bad && cfg_stop_on_err) ? ST_HALT : ST_IDLE;
          else
            state_next = ST_RECV;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  // In IDLE the incoming beat is the first of a frame, so per-frame context
  // is taken from fresh values instead of the stale registers.
  assign first_beat = (state == ST_IDLE);
  assign len_eff    = first_beat ? cfg_frame_bytes : frame_len;
  assign len_base   = first_beat ? '0 : len_acc;
  assign byte_base  = first_beat ? 8'd0 : beat_base;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      beat_bytes = beat_bytes + PW'(xdma_rx_axis_tkeep[i]);
  end

  assign len_sum  = {1'b0, len_base} + {1'b0, beat_bytes};
  assign len_next = len_sum[PW] ? '1 : len_sum[PW-1:0];
  assign len_bad  = (len_next > {1'b0, len_eff}) ||
                    (xdma_rx_axis_tlast && (len_next != {1'b0, len_eff}));

  always_comb begin
    logic [7:0] exp_byte;
    exp_byte = '0;
    data_bad = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      exp_byte = exp_seq[7:0] + byte_base + 8'(i);
      if (xdma_rx_axis_tkeep[i] && (xdma_rx_axis_tdata[8*i +: 8] != exp_byte))
        data_bad = 1'b1;
    end
  end

  // A legal last-beat tkeep is a non-empty run of ones starting at bit 0,
  // i.e. adding one clears every set bit.
  assign keep_plus1 = xdma_rx_axis_tkeep + KEEP_WIDTH'(1);
  assign keep_bad   = xdma_rx_axis_tlast ?
                      ((xdma_rx_axis_tkeep == '0) ||
                       ((xdma_rx_axis_tkeep & keep_plus1) != '0)) :
                      (xdma_rx_axis_tkeep != '1);

  assign beat_flags = {xdma_rx_axis_tuser[0], len_bad, keep_bad, data_bad};
  assign flags_next = (first_beat ? 4'd0 : frame_flags) | beat_flags;
  assign frame_bad  = |flags_next;

  always_ff @(posedge xdma_clk) begin
    if (xdma_reset) begin
      frame_len   <= '0;
      len_acc     <= '0;
      beat_base   <= '0;
      frame_flags <= '0;
      exp_seq     <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      byte_cnt    <= '0;
      err_code    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (beat) begin
        byte_cnt <= byte_cnt + 48'(beat_bytes);
        err_code <= err_code | beat_flags;
        if (xdma_rx_axis_tlast) begin
          frame_done <= 1'b1;
          frame_err  <= frame_bad;
          frame_cnt  <= frame_cnt + CNT_WIDTH'(1);
          exp_seq    <= exp_seq + 16'd1;
          if (frame_bad && (err_cnt != '1))
            err_cnt <= err_cnt + CNT_WIDTH'(1);
        end else begin
          frame_len   <= len_eff;
          len_acc     <= len_next;
          beat_base   <= byte_base + 8'(KEEP_WIDTH);
          frame_flags <= flags_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_xdma_axis_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_xdma_axis_frame_checker
//
// Directed bench for xdma_axis_frame_checker. Frames are built from the
// expected byte pattern (byte i of beat k of frame s = s + 64k + i mod 256)
// and selectively corrupted; results are compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_xdma_axis_frame_checker;

  logic         xdma_clk = 1'b0;
  logic         xdma_reset = 1'b1;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [511:0] tdata = '0;
  logic [63:0]  tkeep = '0;
  logic         tlast = 1'b0;
  logic [0:0]   tuser = '0;
  logic         cfg_enable = 1'b1;
  logic         cfg_stop_on_err = 1'b0;
  logic [15:0]  cfg_frame_bytes = 16'd200;
  logic         frame_done;
  logic         frame_err;
  logic [31:0]  frame_cnt;
  logic [31:0]  err_cnt;
  logic [47:0]  byte_cnt;
  logic [3:0]   err_code;
  logic         halted;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pulse_n = 0;
  int pulse_err_n = 0;
  bit pulse_q[$];

  xdma_axis_frame_checker dut (
    .xdma_clk            (xdma_clk),
    .xdma_reset          (xdma_reset),
    .xdma_rx_axis_tvalid (tvalid),
    .xdma_rx_axis_tready (tready),
    .xdma_rx_axis_tdata  (tdata),
    .xdma_rx_axis_tkeep  (tkeep),
    .xdma_rx_axis_tlast  (tlast),
    .xdma_rx_axis_tuser  (tuser),
    .cfg_enable          (cfg_enable),
    .cfg_stop_on_err     (cfg_stop_on_err),
    .cfg_frame_bytes     (cfg_frame_bytes),
    .frame_done          (frame_done),
    .frame_err           (frame_err),
    .frame_cnt           (frame_cnt),
    .err_cnt             (err_cnt),
    .byte_cnt            (byte_cnt),
    .err_code            (err_code),
    .halted              (halted)
  );

  always #5 xdma_clk = ~xdma_clk;

  always @(posedge xdma_clk) cyc <= cyc + 1;

  // Record every completion pulse and its verdict.
  always @(negedge xdma_clk) begin
    if (frame_done) begin
      pulse_q.push_back(frame_err);
      pulse_n++;
      if (frame_err) pulse_err_n++;
    end
  end

  function automatic logic [511:0] pattern(input int seq, input int k);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(seq + 64*k + i);
    return d;
  endfunction

  function automatic logic [63:0] keep_for(input int nbytes, input int k);
    int rem;
    rem = nbytes - 64*k;
    if (rem >= 64) return '1;
    return (64'd1 << rem) - 64'd1;
  endfunction

  task automatic do_reset();
    xdma_reset = 1'b1;
    tvalid = 1'b0;
    repeat (2) @(posedge xdma_clk);
    #1;
    xdma_reset = 1'b0;
    pulse_q.delete();
    pulse_n = 0;
    pulse_err_n = 0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                           input logic l, input logic u, input int gap);
    int  waited;
    bit  acc;
    if (gap > 0) begin
      tvalid = 1'b0;
      repeat (gap) @(posedge xdma_clk);
      #1;
    end
    tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge xdma_clk);
      acc = tready;
      @(posedge xdma_clk);
      #1;
      waited++;
    end
    tvalid = 1'b0;
    checks++;
    if (!acc) $display("[TB] FAIL beat_accept: accepted=%0b required=1", acc);
    else passes++;
  endtask

  task automatic send_frame(input int seq, input int nbytes, input int bad_byte,
                            input int user_beat, input logic [63:0] last_keep,
                            input bit rand_gap);
    int nb;
    logic [511:0] d;
    logic [63:0]  k;
    nb = (nbytes + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      d = pattern(seq, b);
      if (bad_byte >= 64*b && bad_byte < 64*(b+1))
        d[8*(bad_byte-64*b) +: 8] = d[8*(bad_byte-64*b) +: 8] ^ 8'hFF;
      k = keep_for(nbytes, b);
      if (b == nb-1 && last_keep != '0) k = last_keep;
      send_beat(d, k, (b == nb-1), (b == user_beat),
                rand_gap ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic test_reset();
    cfg_stop_on_err = 1'b0;
    cfg_frame_bytes = 16'd200;
    do_reset();
    send_frame(0, 200, -1, 1, '0, 0);
    repeat (2) @(posedge xdma_clk);
    #1;
    do_reset();
    checks++;
    if ({frame_done, frame_err, halted, err_code} !== 7'd0 ||
        frame_cnt !== 32'd0 || err_cnt !== 32'd0 || byte_cnt !== 48'd0)
      $display("[TB] FAIL reset_outputs: done=%0b err=%0b halt=%0b code=%0h fc=%0d ec=%0d bc=%0d required all 0",
               frame_done, frame_err, halted, err_code, frame_cnt, err_cnt, byte_cnt);
    else passes++;
    checks++;
    if (tready !== 1'b1) $display("[TB] FAIL reset_tready: got %0b required 1", tready);
    else passes++;
    // Partial frame then reset: nothing counted, next frame starts at seq 0.
    send_beat(pattern(0, 0), '1, 1'b0, 1'b0, 0);
    send_beat(pattern(0, 1), '1, 1'b0, 1'b0, 0);
    do_reset();
    send_frame(0, 200, -1, -1, '0, 0);
    repeat (2) @(posedge xdma_clk);
    #1;
    checks++;
    if (frame_cnt !== 32'd1 || err_cnt !== 32'd0 || pulse_n !== 1 || pulse_err_n !== 0)
      $display("[TB] FAIL reset_mid_frame: fc=%0d ec=%0d pulses=%0d bad=%0d required 1/0/1/0",
               frame_cnt, err_cnt, pulse_n, pulse_err_n);
    else passes++;
    checks++;
    if (byte_cnt !== 48'd200) $display("[TB] FAIL reset_mid_bytes: got %0d required 200", byte_cnt);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    cfg_frame_bytes = 16'd200;
    start = cyc;
    for (int s = 0; s < 4; s++) send_frame(s, 200, -1, -1, '0, 0);
    checks++;
    if (cyc - start !== 16) $display("[TB] FAIL b2b_rate: cycles=%0d required 16", cyc - start);
    else passes++;
    repeat (2) @(posedge xdma_clk);
    #1;
    checks++;
    if (pulse_n !== 4 || pulse_err_n !== 0)
      $display("[TB] FAIL b2b_pulses: pulses=%0d bad=%0d required 4/0", pulse_n, pulse_err_n);
    else passes++;
    checks++;
    if (frame_cnt !== 32'd4) $display("[TB] FAIL b2b_frame_cnt: got %0d required 4", frame_cnt);
    else passes++;
    checks++;
    if (byte_cnt !== 48'd800) $display("[TB] FAIL b2b_byte_cnt: got %0d required 800", byte_cnt);
    else passes++;
    checks++;
    if (err_code !== 4'b0000 || err_cnt !== 32'd0)
      $display("[TB] FAIL b2b_errors: code=%0h ec=%0d required 0/0", err_code, err_cnt);
    else passes++;
  endtask

  task automatic test_data_error();
    do_reset();
    cfg_stop_on_err = 1'b0;
    send_frame(0, 200, -1, -1, '0, 0);
    send_frame(1, 200, 70, -1, '0, 0);
    send_frame(2, 200, -1, -1, '0, 0);
    repeat (2) @(posedge xdma_clk);
    #1;
    checks++;
    if (pulse_q.size() !== 3 || pulse_q[0] !== 1'b0 || pulse_q[1] !== 1'b1 || pulse_q[2] !== 1'b0)
      $display("[TB] FAIL data_err_pulses: n=%0d bad=%0d required 3 pulses, only second bad",
               pulse_q.size(), pulse_err_n);
    else passes++;
    checks++;
    if (err_code !== 4'b0001) $display("[TB] FAIL data_err_code: got %b required 0001", err_code);
    else passes++;
    checks++;
    if (err_cnt !== 32'd1 || frame_cnt !== 32'd3)
      $display("[TB] FAIL data_err_counts: ec=%0d fc=%0d required 1/3", err_cnt, frame_cnt);
    else passes++;
  endtask

  task automatic test_keep_error();
    do_reset();
    send_frame(0, 200, -1, -1, 64'hF0, 0);
    repeat (2) @(posedge xdma_clk);
    #1;
    checks++;
    if (err_code !== 4'b0110) $display("[TB] FAIL keep_err_code: got %b required 0110", err_code);
    else passes++;
    checks++;
    if (pulse_n !== 1 || pulse_err_n !== 1 || err_cnt !== 32'd1)
      $display("[TB] FAIL keep_err_frame: pulses=%0d bad=%0d ec=%0d required 1/1/1",
               pulse_n, pulse_err_n, err_cnt);
    else passes++;
  endtask

  task automatic test_length();
    do_reset();
    cfg_frame_bytes = 16'd200;
    for (int b = 0; b < 3; b++) send_beat(pattern(0, b), '1, 1'b0, 1'b0, 0);
    checks++;
    if (err_code !== 4'b0000) $display("[TB] FAIL len_before_overrun: got %b required 0000", err_code);
    else passes++;
    send_beat(pattern(0, 3), '1, 1'b0, 1'b0, 0);
    checks++;
    if (err_code !== 4'b0100 || pulse_n !== 0)
      $display("[TB] FAIL len_overrun_flag: code=%b pulses=%0d required 0100/0", err_code, pulse_n);
    else passes++;
    send_beat(pattern(0, 4), 64'hFF, 1'b1, 1'b0, 0);
    repeat (2) @(posedge xdma_clk);
    #1;
    checks++;
    if (err_cnt !== 32'd1 || frame_cnt !== 32'd1 || pulse_n !== 1 || pulse_err_n !== 1)
      $display("[TB] FAIL len_counted_once: ec=%0d fc=%0d pulses=%0d bad=%0d required 1/1/1/1",
               err_cnt, frame_cnt, pulse_n, pulse_err_n);
    else passes++;
    checks++;
    if (byte_cnt !== 48'd264 || err_code !== 4'b0100)
      $display("[TB] FAIL len_bytes: bc=%0d code=%b required 264/0100", byte_cnt, err_code);
    else passes++;
  endtask

  task automatic test_stop_on_err();
    int seen;
    do_reset();
    cfg_stop_on_err = 1'b1;
    send_frame(0, 200, -1, 1, '0, 0);
    checks++;
    if (frame_done !== 1'b1 || frame_err !== 1'b1 || halted !== 1'b1 || tready !== 1'b0)
      $display("[TB] FAIL halt_pulse_cycle: done=%0b err=%0b halt=%0b ready=%0b required 1/1/1/0",
               frame_done, frame_err, halted, tready);
    else passes++;
    tdata = pattern(1, 0); tkeep = '1; tlast = 1'b1; tuser = 1'b0; tvalid = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge xdma_clk);
      if (tready) seen++;
    end
    tvalid = 1'b0;
    @(posedge xdma_clk);
    #1;
    checks++;
    if (seen !== 0 || byte_cnt !== 48'd200 || frame_cnt !== 32'd1 || pulse_n !== 1)
      $display("[TB] FAIL halt_ignores: ready_cycles=%0d bc=%0d fc=%0d pulses=%0d required 0/200/1/1",
               seen, byte_cnt, frame_cnt, pulse_n);
    else passes++;
    checks++;
    if (err_code !== 4'b1000 || err_cnt !== 32'd1)
      $display("[TB] FAIL halt_err: code=%b ec=%0d required 1000/1", err_code, err_cnt);
    else passes++;
    do_reset();
    cfg_stop_on_err = 1'b0;
    checks++;
    if (halted !== 1'b0 || tready !== 1'b1 || err_code !== 4'd0 || frame_cnt !== 32'd0)
      $display("[TB] FAIL halt_reset: halt=%0b ready=%0b code=%b fc=%0d required 0/1/0000/0",
               halted, tready, err_code, frame_cnt);
    else passes++;
  endtask

  task automatic test_stall();
    int seen;
    do_reset();
    cfg_frame_bytes = 16'd200;
    send_beat(pattern(0, 0), '1, 1'b0, 1'b0, 1);
    cfg_enable = 1'b0;
    tdata = pattern(0, 1); tkeep = '1; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge xdma_clk);
      if (tready) seen++;
      @(posedge xdma_clk);
      #1;
    end
    checks++;
    if (seen !== 0 || byte_cnt !== 48'd64)
      $display("[TB] FAIL stall_blocked: ready_cycles=%0d bc=%0d required 0/64", seen, byte_cnt);
    else passes++;
    cfg_enable = 1'b1;
    send_beat(pattern(0, 1), '1, 1'b0, 1'b0, 0);
    send_beat(pattern(0, 2), '1, 1'b0, 1'b0, int'($urandom_range(0, 2)));
    send_beat(pattern(0, 3), 64'hFF, 1'b1, 1'b0, int'($urandom_range(0, 2)));
    send_frame(1, 200, -1, -1, '0, 1);
    repeat (2) @(posedge xdma_clk);
    #1;
    checks++;
    if (frame_cnt !== 32'd2 || pulse_n !== 2 || pulse_err_n !== 0)
      $display("[TB] FAIL stall_frames: fc=%0d pulses=%0d bad=%0d required 2/2/0",
               frame_cnt, pulse_n, pulse_err_n);
    else passes++;
    checks++;
    if (byte_cnt !== 48'd400 || err_code !== 4'd0)
      $display("[TB] FAIL stall_bytes: bc=%0d code=%b required 400/0000", byte_cnt, err_code);
    else passes++;
  endtask

  task automatic test_seq_wrap();
    do_reset();
    cfg_frame_bytes = 16'd64;
    for (int s = 0; s < 65537; s++) send_beat(pattern(s, 0), '1, 1'b1, 1'b0, 0);
    repeat (2) @(posedge xdma_clk);
    #1;
    checks++;
    if (frame_cnt !== 32'd65537 || pulse_n !== 65537)
      $display("[TB] FAIL wrap_frames: fc=%0d pulses=%0d required 65537", frame_cnt, pulse_n);
    else passes++;
    checks++;
    if (err_cnt !== 32'd0 || err_code !== 4'd0 || pulse_err_n !== 0)
      $display("[TB] FAIL wrap_errors: ec=%0d code=%b bad=%0d required 0", err_cnt, err_code, pulse_err_n);
    else passes++;
    checks++;
    if (byte_cnt !== 48'd4194368)
      $display("[TB] FAIL wrap_bytes: got %0d required 4194368", byte_cnt);
    else passes++;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_back_to_back();
    test_data_error();
    test_keep_error();
    test_length();
    test_stop_on_err();
    test_stall();
    test_seq_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
